// File: rtl/melody_sequencer_if.sv
// Song sequencer bus: playback control, song ROM port and tone outputs.
interface melody_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [9:0]        rom_data;
    logic [31:0]       div;
    logic              mute;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, rom_data,
        input  rom_addr, div, mute, busy, done
    );

    modport slave (
        input  start, stop, rom_data,
        output rom_addr, div, mute, busy, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// Steps a song ROM and drives the music_freq half-period divider and mute.
module melody_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 6_250_000,
    parameter int GAP_CYC  = 500_000,
    parameter bit LOOP     = 1'b0
) (
    input logic               clk,
    input logic               rst,
    melody_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
    localparam bit          HAS_GAP   = (GAP_CYC > 0);

    state_t            state_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [31:0]       div_q;
    logic              mute_q;
    logic              done_q;
    logic [31:0]       tick_q;
    logic [3:0]        dur_q;

    logic [1:0]  oct;
    logic [3:0]  pitch;
    logic [3:0]  dur;
    logic        rest;
    logic [31:0] note_d;
    logic [3:0]  dur_d;
    logic        tick_end;
    logic        gap_end;
    logic        adv_d;
    logic        fin_d;

    assign oct   = bus.rom_data[9:8];
    assign pitch = bus.rom_data[7:4];
    assign dur   = bus.rom_data[3:0];
    assign rest  = (pitch == 4'd0) || (pitch > 4'd12);
    assign dur_d = (dur == 4'd0) ? 4'd1 : dur;

    // Octave-4 half-period bases; higher octaves halve (B+1).
    always_comb begin
        logic [31:0] base;
        logic [1:0]  sh;
        base = 32'd0;
        case (pitch)
            4'd1:    base = 32'd95555;
            4'd2:    base = 32'd90193;
            4'd3:    base = 32'd85130;
            4'd4:    base = 32'd80351;
            4'd5:    base = 32'd75841;
            4'd6:    base = 32'd71585;
            4'd7:    base = 32'd67568;
            4'd8:    base = 32'd63775;
            4'd9:    base = 32'd60196;
            4'd10:   base = 32'd56817;
            4'd11:   base = 32'd53628;
            4'd12:   base = 32'd50618;
            default: base = 32'd0;
        endcase
        sh     = (oct == 2'd3) ? 2'd2 : oct;
        note_d = rest ? 32'd0 : (((base + 32'd1) >> sh) - 32'd1);
    end

    assign tick_end = (tick_q == TICK_LAST);
    assign gap_end  = HAS_GAP && (tick_q == GAP_LAST);

    // Leaving a note; the last address acts like an end marker.
    assign adv_d = (state_q == S_PLAY && tick_end && dur_q == 4'd1 && !HAS_GAP)
                || (state_q == S_GAP && gap_end);
    assign fin_d = (state_q == S_LOAD && pitch == 4'hF)
                || (adv_d && rom_addr_q == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            div_q      <= '0;
            mute_q     <= 1'b1;
            done_q     <= 1'b0;
            tick_q     <= '0;
            dur_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                mute_q  <= 1'b1;
                div_q   <= '0;
                tick_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            rom_addr_q <= '0;
                            state_q    <= S_FETCH;
                        end
                    end
                    S_FETCH: state_q <= S_LOAD;
                    S_LOAD: begin
                        if (pitch != 4'hF) begin
                            div_q   <= note_d;
                            mute_q  <= rest;
                            dur_q   <= dur_d;
                            tick_q  <= '0;
                            state_q <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (tick_end) begin
                            tick_q <= '0;
                            if (dur_q == 4'd1) begin
                                mute_q <= 1'b1;
                                if (HAS_GAP) state_q <= S_GAP;
                            end else begin
                                dur_q <= dur_q - 4'd1;
                            end
                        end else begin
                            tick_q <= tick_q + 32'd1;
                        end
                    end
                    S_GAP: begin
                        if (gap_end) tick_q <= '0;
                        else         tick_q <= tick_q + 32'd1;
                    end
                    default: state_q <= S_IDLE;
                endcase
                if (adv_d && !fin_d) begin
                    rom_addr_q <= rom_addr_q + 1'b1;
                    state_q    <= S_FETCH;
                end
                if (fin_d) begin
                    if (LOOP) begin
                        rom_addr_q <= '0;
                        state_q    <= S_FETCH;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.div      = div_q;
    assign bus.mute     = mute_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
endmodule
